// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_pkg : SPI mode decode and bit-count constants shared by master/slave   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package spi_pkg;

  localparam int c_SPI_BIT_CNT_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  function automatic logic spi_cpol(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic spi_cpha(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer with parameterized width and reset value  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o_Q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_D;
      r_sync <= r_meta;
    end
  end

  assign o_Q = r_sync;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave : oversampled SPI slave, all four modes, one-byte TX holding reg |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module spi_slave
  import spi_pkg::*;
#(
  parameter int         SPI_MODE        = 0,
  parameter logic [7:0] DEFAULT_TX_BYTE = 8'hFF
) (
  input  logic       i_Rst_L,
  input  logic       i_Clk,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);

  localparam logic c_CPOL = spi_cpol(SPI_MODE);
  localparam logic c_CPHA = spi_cpha(SPI_MODE);

  logic [2:0] w_sync;
  logic       w_sclk_s;
  logic       w_cs_n_s;
  logic       w_mosi_s;

  sync_2ff #(
    .WIDTH   (3),
    .RST_VAL ({c_CPOL, 1'b1, 1'b0})
  ) u_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_D     ({i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI}),
    .o_Q     (w_sync)
  );

  assign {w_sclk_s, w_cs_n_s, w_mosi_s} = w_sync;

  logic r_sclk_d;
  logic r_cs_n_d;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sclk_d <= c_CPOL;
      r_cs_n_d <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_cs_n_d <= w_cs_n_s;
    end
  end

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_lead;
  logic w_trail;
  logic w_cs_fall;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_lead      = c_CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = c_CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_cs_fall   = ~w_cs_n_s & r_cs_n_d;

  spi_state_t                 r_state;
  spi_state_t                 w_state_nxt;
  logic [c_SPI_BIT_CNT_W-1:0] r_bit_cnt;
  logic                       w_sample;
  logic                       w_shift;
  logic                       w_byte_start;
  logic                       w_abort;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // CPHA=0 skips the trailing edge of bit 0: the new byte's bit 7 is already on MISO.
  always_comb begin
    w_state_nxt  = r_state;
    w_sample     = 1'b0;
    w_shift      = 1'b0;
    w_byte_start = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt  = ST_ACTIVE;
          w_byte_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_n_s) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_sample     = c_CPHA ? w_trail : w_lead;
          w_shift      = c_CPHA ? w_lead : (w_trail && (r_bit_cnt != '1));
          w_byte_start = w_sample && (r_bit_cnt == '0);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic [7:0] r_hold;
  logic       r_hold_full;
  logic [7:0] r_tx_shift;
  logic       r_miso;
  logic [6:0] r_rx_shift;
  logic [7:0] r_rx_byte;
  logic       r_rx_dv;
  logic [7:0] w_tx_load;
  logic       w_tx_accept;

  assign w_tx_load   = r_hold_full ? r_hold : (i_TX_DV ? i_TX_Byte : DEFAULT_TX_BYTE);
  assign w_tx_accept = i_TX_DV & ~r_hold_full;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_bit_cnt   <= '1;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_tx_shift  <= 8'h00;
      r_miso      <= 1'b0;
      r_rx_shift  <= 7'h00;
      r_rx_byte   <= 8'h00;
      r_rx_dv     <= 1'b0;
    end else begin
      r_rx_dv <= 1'b0;

      if (w_abort) begin
        r_bit_cnt  <= '1;
        r_rx_shift <= 7'h00;
        r_tx_shift <= 8'h00;
        r_miso     <= 1'b0;
      end

      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt - 1'b1;
        if (r_bit_cnt == '0) begin
          r_rx_byte <= {r_rx_shift, w_mosi_s};
          r_rx_dv   <= 1'b1;
        end
      end

      if (w_shift) begin
        r_miso     <= r_tx_shift[7];
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end

      // A strobe that lands on byte start with the holding register empty bypasses it.
      if (w_byte_start) begin
        if (c_CPHA) begin
          r_tx_shift <= w_tx_load;
        end else begin
          r_miso     <= w_tx_load[7];
          r_tx_shift <= {w_tx_load[6:0], 1'b0};
        end
        r_hold_full <= 1'b0;
      end else if (w_tx_accept) begin
        r_hold      <= i_TX_Byte;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign o_TX_Ready    = ~r_hold_full;
  assign o_RX_DV       = r_rx_dv;
  assign o_RX_Byte     = r_rx_byte;
  assign o_SPI_MISO_En = ~w_cs_n_s;
  assign o_SPI_MISO    = ~w_cs_n_s & r_miso;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_slave : drives one slave per SPI mode with a behavioural master      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_spi_slave;

  localparam int HALF = 50;

  logic i_Clk   = 1'b0;
  logic i_Rst_L = 1'b0;
  always #5 i_Clk = ~i_Clk;

  logic [3:0]      sclk    = 4'b1100;
  logic [3:0]      cs_n    = 4'hF;
  logic [3:0]      mosi    = 4'h0;
  logic [3:0]      tx_dv   = 4'h0;
  logic [3:0][7:0] tx_byte = '0;
  wire  [3:0]      tx_ready;
  wire  [3:0]      rx_dv;
  wire  [3:0]      miso;
  wire  [3:0]      miso_en;
  wire  [3:0][7:0] rx_byte;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(
      .SPI_MODE        (g),
      .DEFAULT_TX_BYTE (8'hFF)
    ) u_dut (
      .i_Rst_L       (i_Rst_L),
      .i_Clk         (i_Clk),
      .i_TX_Byte     (tx_byte[g]),
      .i_TX_DV       (tx_dv[g]),
      .o_TX_Ready    (tx_ready[g]),
      .o_RX_DV       (rx_dv[g]),
      .o_RX_Byte     (rx_byte[g]),
      .i_SPI_Clk     (sclk[g]),
      .i_SPI_CS_n    (cs_n[g]),
      .i_SPI_MOSI    (mosi[g]),
      .o_SPI_MISO    (miso[g]),
      .o_SPI_MISO_En (miso_en[g])
    );
  end

  typedef struct {
    int         mode;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    int         mode;
    logic [7:0] tx_q;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  sb_t        sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         rx_cnt [4];
  logic [3:0] rx_dv_prev = 4'h0;

  function automatic logic tb_cpol(input int m);
    return m >= 2;
  endfunction

  function automatic logic tb_cpha(input int m);
    return (m % 2) == 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard side: every o_RX_DV pulse pops one expected byte.
  always @(negedge i_Clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_dv[m]) begin
        sb_t e;
        rx_cnt[m]++;
        chk($sformatf("rx_dv_width_m%0d", m), {31'd0, rx_dv_prev[m]}, 0);
        if (sb_q.size() == 0) begin
          chk($sformatf("rx_unexpected_m%0d", m), sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("rx_mode_m%0d", m), m, e.mode);
          chk($sformatf("rx_byte_m%0d", m), {24'd0, rx_byte[m]}, {24'd0, e.data});
        end
      end
    end
    rx_dv_prev = rx_dv;
  end

  task automatic load_tx(input int m, input logic [7:0] b);
    @(posedge i_Clk); #1;
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    @(posedge i_Clk); #1;
    tx_dv[m]   = 1'b0;
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    #(2*HALF);
  endtask

  task automatic cs_high(input int m);
    #(HALF);
    cs_n[m] = 1'b1;
    #(2*HALF);
  endtask

  task automatic xfer(input int m, input logic [7:0] d, input int nbits, output logic [7:0] got);
    got = 8'h00;
    if (nbits == 8) sb_q.push_back('{m, d});
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!tb_cpha(m)) begin
        mosi[m] = d[i];
        #(HALF);
        sclk[m] = ~tb_cpol(m);
        got[i]  = miso[m];
        #(HALF);
        sclk[m] = tb_cpol(m);
      end else begin
        sclk[m] = ~tb_cpol(m);
        mosi[m] = d[i];
        #(HALF);
        sclk[m] = tb_cpol(m);
        got[i]  = miso[m];
        #(HALF);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge i_Clk);
    chk(name, sb_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [6];
    logic [7:0] got;
    logic [7:0] got1;
    logic [7:0] got2;
    int         base;
    int         m;

    tbl[0] = '{0, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
    tbl[1] = '{1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    tbl[2] = '{2, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    tbl[3] = '{3, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    tbl[4] = '{0, 8'h00, 8'hFF, 8'h00, 8'hFF};
    tbl[5] = '{2, 8'hE1, 8'h1E, 8'hE1, 8'h1E};
    for (int k = 0; k < 4; k++) rx_cnt[k] = 0;

    i_Rst_L = 1'b0;
    repeat (5) @(posedge i_Clk);
    #1;
    chk("rst_tx_ready", {28'd0, tx_ready}, 32'hF);
    chk("rst_rx_dv", {28'd0, rx_dv}, 0);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_miso", {28'd0, miso}, 0);
    chk("rst_miso_en", {28'd0, miso_en}, 0);
    i_Rst_L = 1'b1;
    #(2*HALF);

    for (int i = 0; i < 6; i++) begin
      m = tbl[i].mode;
      load_tx(m, tbl[i].tx_q);
      chk($sformatf("vec%0d_ready_low", i), {31'd0, tx_ready[m]}, 0);
      cs_low(m);
      xfer(m, tbl[i].mosi, 8, got);
      cs_high(m);
      chk($sformatf("vec%0d_miso", i), {24'd0, got}, {24'd0, tbl[i].exp_miso});
      wait_drain($sformatf("vec%0d_drain", i));
      chk($sformatf("vec%0d_rx_byte", i), {24'd0, rx_byte[m]}, {24'd0, tbl[i].exp_rx});
    end

    // Three bytes under one CS, only the first queued.
    load_tx(0, 8'h69);
    base = rx_cnt[0];
    cs_low(0);
    xfer(0, 8'h11, 8, got);
    xfer(0, 8'h22, 8, got1);
    xfer(0, 8'h33, 8, got2);
    cs_high(0);
    chk("b2b_miso0", {24'd0, got}, 32'h69);
    chk("b2b_miso1", {24'd0, got1}, 32'hFF);
    chk("b2b_miso2", {24'd0, got2}, 32'hFF);
    wait_drain("b2b_drain");
    chk("b2b_rx_count", rx_cnt[0] - base, 3);

    // CS rise after 5 bits; the queued byte must survive for the next transfer.
    cs_low(0);
    load_tx(0, 8'h96);
    chk("part_ready_low", {31'd0, tx_ready[0]}, 0);
    base = rx_cnt[0];
    xfer(0, 8'hAA, 5, got);
    cs_high(0);
    chk("part_no_rx", rx_cnt[0] - base, 0);
    chk("part_hold_kept", {31'd0, tx_ready[0]}, 0);
    cs_low(0);
    xfer(0, 8'h81, 8, got);
    cs_high(0);
    chk("part_next_miso", {24'd0, got}, 32'h96);
    wait_drain("part_drain");
    chk("part_rx_byte", {24'd0, rx_byte[0]}, 32'h81);

    // Strobe exactly on the byte-start cycle: CS pin -> 2 sync flops -> edge stage.
    @(posedge i_Clk); #1;
    cs_n[0] = 1'b0;
    repeat (2) @(posedge i_Clk);
    #1;
    tx_byte[0] = 8'hB4;
    tx_dv[0]   = 1'b1;
    @(posedge i_Clk); #1;
    tx_dv[0]   = 1'b0;
    #1;
    chk("direct_ready_high", {31'd0, tx_ready[0]}, 1);
    load_tx(0, 8'h4B);
    chk("direct_hold_ready_low", {31'd0, tx_ready[0]}, 0);
    load_tx(0, 8'hE7);
    #(2*HALF);
    xfer(0, 8'h01, 8, got);
    xfer(0, 8'h02, 8, got1);
    xfer(0, 8'h03, 8, got2);
    cs_high(0);
    chk("direct_miso0", {24'd0, got}, 32'hB4);
    chk("direct_miso1", {24'd0, got1}, 32'h4B);
    chk("direct_miso2_ignored", {24'd0, got2}, 32'hFF);
    wait_drain("direct_drain");

    // Reset at bit 4 of a mode-1 transfer with a byte waiting in the holding register.
    load_tx(1, 8'hD2);
    cs_low(1);
    load_tx(1, 8'h77);
    chk("rstmid_ready_low", {31'd0, tx_ready[1]}, 0);
    base = rx_cnt[1];
    xfer(1, 8'hF0, 4, got);
    i_Rst_L = 1'b0;
    #3;
    chk("rstmid_ready", {31'd0, tx_ready[1]}, 1);
    chk("rstmid_rx_dv", {31'd0, rx_dv[1]}, 0);
    chk("rstmid_rx_byte", {24'd0, rx_byte[1]}, 0);
    chk("rstmid_miso", {31'd0, miso[1]}, 0);
    chk("rstmid_miso_en", {31'd0, miso_en[1]}, 0);
    sclk[1] = 1'b0;
    cs_n[1] = 1'b1;
    #(2*HALF);
    i_Rst_L = 1'b1;
    #(2*HALF);
    chk("rstmid_no_rx", rx_cnt[1] - base, 0);
    cs_low(1);
    xfer(1, 8'h3E, 8, got);
    cs_high(1);
    chk("rstmid_next_miso", {24'd0, got}, 32'hFF);
    wait_drain("rstmid_drain");
    chk("rstmid_rx_count", rx_cnt[1] - base, 1);
    chk("rstmid_rx_byte_after", {24'd0, rx_byte[1]}, 32'h3E);

    #(2*HALF);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SPI_MODE, default 0, selects CPOL/CPHA: 0=(0,0), 1=(0,1), 2=(1,0), 3=(1,1).
REQ-002 Parameter DEFAULT_TX_BYTE, default 8'hFF, is the byte shifted out when no user byte is queued.
REQ-003 i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-004 i_Clk  input  1  system clock, at least 8x the SPI clock frequency.
REQ-005 i_TX_Byte  input  8  byte queued for MISO.
REQ-006 i_TX_DV  input  1  one-cycle load strobe for i_TX_Byte.
REQ-007 o_TX_Ready  output  1  holding register empty; i_TX_DV is accepted only while this is high.
REQ-008 o_RX_DV  output  1  one-cycle pulse when a full byte has been received.
REQ-009 o_RX_Byte  output  8  last complete received byte, MSb first on the wire.
REQ-010 i_SPI_Clk  input  1  SPI clock from master; asynchronous to i_Clk.
REQ-011 i_SPI_CS_n  input  1  chip select, active-low; asynchronous to i_Clk.
REQ-012 i_SPI_MOSI  input  1  serial data from master.
REQ-013 o_SPI_MISO  output  1  serial data to master.
REQ-014 o_SPI_MISO_En  output  1  MISO output enable; high only while selected.

Function
REQ-015 i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals one stage later.
REQ-016 Leading edge SHALL be rising for CPOL=0 and falling for CPOL=1; SPI clock edges SHALL be ignored while CS_n is high.
REQ-017 FSM states: IDLE (CS_n high) and ACTIVE (CS_n low); a CS_n falling edge moves IDLE->ACTIVE, a rising edge moves ACTIVE->IDLE.
REQ-018 Byte start occurs on IDLE->ACTIVE and after every 8th sample edge while ACTIVE.
REQ-019 At byte start, the shift register SHALL load from the holding register if full (o_TX_Ready rises the next cycle), else from DEFAULT_TX_BYTE.
REQ-020 If i_TX_DV coincides with a byte start while the holding register is empty, i_TX_Byte SHALL load the shift register directly and the holding register SHALL stay empty.
REQ-021 i_TX_DV while o_TX_Ready is low SHALL be ignored.
REQ-022 CPHA=0: at byte start, MISO SHALL present bit 7; sample MOSI on the leading edge; shift MISO on the trailing edge.
REQ-023 CPHA=1: shift MISO on the leading edge (first leading edge presents bit 7); sample MOSI on the trailing edge.
REQ-024 On the 8th sample, o_RX_Byte SHALL update and o_RX_DV SHALL pulse for exactly one cycle, no more than 4 i_Clk cycles after the SPI pin edge.
REQ-025 A CS_n rise mid-byte SHALL discard the partial RX and TX bytes, generate no o_RX_DV, reset the bit counter to 7, and leave the holding register unchanged.
REQ-026 The bit counter SHALL be 3 bits and wrap from 0 to 7 at each byte boundary, with no gap between consecutive bytes.
REQ-027 o_SPI_MISO_En SHALL equal the inverted synchronized CS_n; o_SPI_MISO SHALL be 0 while disabled.

Reset
REQ-028 On reset: FSM=IDLE, o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=8'h00, o_SPI_MISO=0, o_SPI_MISO_En=0, bit counter=7, holding register empty, synchronizers preset to CS_n=1 and SPI_Clk=CPOL.
REQ-029 Reset asserted mid-transfer SHALL abort immediately; no o_RX_DV SHALL pulse after release until a new complete byte arrives.

Structure
REQ-030 Shared package spi_pkg SHALL hold the CPOL/CPHA decode functions for SPI_MODE and the bit-count width constant, shared with the SPI master.
REQ-031 A sub-module sync_2ff (parameterized width, reset value) SHALL implement the input synchronizers.

Verification
REQ-032 Mode 0, master sends 8'hA5 while the slave has 8'h3C queued -> o_RX_Byte=8'hA5 with one o_RX_DV pulse; master receives 8'h3C.
REQ-033 Modes 1, 2 and 3, each exchanging 8'hC3 <-> 8'h5A -> correct bytes in both directions.
REQ-034 Three back-to-back bytes under one CS, only the first queued -> master receives queued byte, then 8'hFF, 8'hFF; three o_RX_DV pulses.
REQ-035 CS_n deasserted after 5 bits, then a new 8'h81 transfer -> no o_RX_DV for the partial byte; 8'h81 received correctly.
REQ-036 i_TX_DV on the byte-start cycle with holding empty; second i_TX_DV while o_TX_Ready is low -> first byte sent, second ignored.
REQ-037 Reset asserted at bit 4 -> all outputs return to reset values; the next transfer is correct.
